// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction sequencer: opcode, ALU function and
// step encodings plus instruction-register field positions.
package cpu_pkg;

  localparam int unsigned IrWidth = 10;
  localparam int unsigned OpMsb   = 9;
  localparam int unsigned OpLsb   = 6;
  localparam int unsigned RxMsb   = 5;
  localparam int unsigned RxLsb   = 4;
  localparam int unsigned RyMsb   = 3;
  localparam int unsigned RyLsb   = 2;

  // Opcodes 8..15 are not enumerated and decode as NOP.
  typedef enum logic [3:0] {
    OpLoad = 4'd0,
    OpMov  = 4'd1,
    OpAdd  = 4'd2,
    OpSub  = 4'd3,
    OpInv  = 4'd4,
    OpFlip = 4'd5,
    OpAddi = 4'd6,
    OpSubi = 4'd7
  } op_e;

  typedef enum logic [2:0] {
    AluPass = 3'd0,
    AluAdd  = 3'd1,
    AluSub  = 3'd2,
    AluInv  = 3'd3,
    AluFlip = 3'd4
  } alu_op_e;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_e;

  function automatic logic [3:0] reg_sel(input logic [1:0] idx);
    reg_sel = 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/instr_sequencer.sv
// Multi-step control sequencer for a four-register bus CPU: latches an
// instruction in T0 and emits Moore control signals for steps T1..T3.
module instr_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                exec,
  input  logic [IrWidth-1:0]  din,
  output logic                ext_en,
  output logic [3:0]          r_out,
  output logic [3:0]          r_in,
  output logic                a_in,
  output logic                g_in,
  output logic                g_out,
  output logic [2:0]          alu_op,
  output logic [1:0]          time_step,
  output logic                done
);

  step_e              step_q, step_d;
  logic [IrWidth-1:0] ir_q;
  logic               ir_load;
  logic [2:0]         step_inc;
  op_e                op;
  logic [1:0]         rx, ry;
  logic               unused_bits;

  assign op          = op_e'(ir_q[OpMsb:OpLsb]);
  assign rx          = ir_q[RxMsb:RxLsb];
  assign ry          = ir_q[RyMsb:RyLsb];
  assign step_inc    = {1'b0, step_q} + 3'd1;
  assign time_step   = step_q;
  assign unused_bits = ^{ir_q[1:0], step_inc[2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q <= T0;
      ir_q   <= '0;
    end else begin
      step_q <= step_d;
      if (ir_load) ir_q <= din;
    end
  end

  always_comb begin
    ext_en  = 1'b0;
    r_out   = 4'b0000;
    r_in    = 4'b0000;
    a_in    = 1'b0;
    g_in    = 1'b0;
    g_out   = 1'b0;
    alu_op  = AluPass;
    done    = 1'b0;
    ir_load = 1'b0;
    step_d  = step_q;

    unique case (step_q)
      T0: begin
        if (exec) begin
          ir_load = 1'b1;
          step_d  = T1;
        end
      end
      T1: begin
        case (op)
          OpLoad: begin
            ext_en = 1'b1;
            r_in   = reg_sel(rx);
            done   = 1'b1;
          end
          OpMov: begin
            r_out = reg_sel(ry);
            r_in  = reg_sel(rx);
            done  = 1'b1;
          end
          OpAdd, OpSub, OpAddi, OpSubi, OpInv, OpFlip: begin
            r_out = reg_sel(rx);
            a_in  = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        g_in = 1'b1;
        case (op)
          OpAdd: begin
            r_out  = reg_sel(ry);
            alu_op = AluAdd;
          end
          OpSub: begin
            r_out  = reg_sel(ry);
            alu_op = AluSub;
          end
          OpAddi: begin
            ext_en = 1'b1;
            alu_op = AluAdd;
          end
          OpSubi: begin
            ext_en = 1'b1;
            alu_op = AluSub;
          end
          OpInv:  alu_op = AluInv;
          OpFlip: alu_op = AluFlip;
          // Single-step ops never reach T2; terminate cleanly if they do.
          default: begin
            g_in = 1'b0;
            done = 1'b1;
          end
        endcase
      end
      T3: begin
        case (op)
          OpAdd, OpSub, OpAddi, OpSubi, OpInv, OpFlip: begin
            g_out = 1'b1;
            r_in  = reg_sel(rx);
          end
          default: ;
        endcase
        done = 1'b1;
      end
      default: ;
    endcase

    if (done) begin
      step_d = T0;
    end else if (step_q != T0) begin
      step_d = step_e'(step_inc[1:0]);
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: a table-driven instruction model
// queues expected per-step outputs; a negedge monitor pops and compares.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       exec;
  logic [9:0] din;
  logic       ext_en, a_in, g_in, g_out, done;
  logic [3:0] r_out, r_in;
  logic [2:0] alu_op;
  logic [1:0] time_step;

  typedef struct packed {
    logic [1:0] step;
    logic       ext_en;
    logic [3:0] r_out;
    logic [3:0] r_in;
    logic       a_in;
    logic       g_in;
    logic       g_out;
    logic [2:0] alu_op;
    logic       done;
  } obs_t;

  obs_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  instr_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .exec      (exec),
    .din       (din),
    .ext_en    (ext_en),
    .r_out     (r_out),
    .r_in      (r_in),
    .a_in      (a_in),
    .g_in      (g_in),
    .g_out     (g_out),
    .alu_op    (alu_op),
    .time_step (time_step),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic obs_t observe();
    obs_t o;
    o.step   = time_step;
    o.ext_en = ext_en;
    o.r_out  = r_out;
    o.r_in   = r_in;
    o.a_in   = a_in;
    o.g_in   = g_in;
    o.g_out  = g_out;
    o.alu_op = alu_op;
    o.done   = done;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b required %b (step,ext,rout,rin,a,gi,go,alu,done)",
               name, act, req);
    end
  endtask

  // Reference model: expected outputs for each step of an instruction.
  task automatic push_expected(input logic [9:0] ins);
    int   op;
    int   rx;
    int   ry;
    obs_t e;
    op = int'(ins[9:6]);
    rx = int'(ins[5:4]);
    ry = int'(ins[3:2]);
    e = '0;
    e.step = 2'd1;
    if (op == 0) begin
      e.ext_en = 1'b1; e.r_in = 4'(1 << rx); e.done = 1'b1;
      exp_q.push_back(e);
    end else if (op == 1) begin
      e.r_out = 4'(1 << ry); e.r_in = 4'(1 << rx); e.done = 1'b1;
      exp_q.push_back(e);
    end else if (op >= 2 && op <= 7) begin
      e.r_out = 4'(1 << rx); e.a_in = 1'b1;
      exp_q.push_back(e);
      e = '0;
      e.step = 2'd2;
      e.g_in = 1'b1;
      case (op)
        2: begin e.r_out = 4'(1 << ry); e.alu_op = 3'd1; end
        3: begin e.r_out = 4'(1 << ry); e.alu_op = 3'd2; end
        4: e.alu_op = 3'd3;
        5: e.alu_op = 3'd4;
        6: begin e.ext_en = 1'b1; e.alu_op = 3'd1; end
        default: begin e.ext_en = 1'b1; e.alu_op = 3'd2; end
      endcase
      exp_q.push_back(e);
      e = '0;
      e.step = 2'd3;
      e.g_out = 1'b1; e.r_in = 4'(1 << rx); e.done = 1'b1;
      exp_q.push_back(e);
    end else begin
      e.done = 1'b1;
      exp_q.push_back(e);
    end
  endtask

  function automatic int ins_len(input logic [9:0] ins);
    int op;
    op = int'(ins[9:6]);
    return (op >= 2 && op <= 7) ? 3 : 1;
  endfunction

  // Called #1 after a posedge with the DUT in T0. spurious: pulse exec mid-instruction.
  task automatic run_instr(input logic [9:0] ins, input bit spurious, input logic [9:0] imm);
    int n;
    n = ins_len(ins);
    push_expected(ins);
    exec = 1'b1;
    din  = ins;
    @(posedge clk); #1;
    for (int i = 0; i < n; i++) begin
      exec = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      if (spurious && i == 1) exec = 1'b1;
      din  = (i == 1) ? imm : 10'($urandom);
      @(posedge clk); #1;
    end
    exec = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  always @(negedge clk) begin
    obs_t act;
    act = observe();
    checks++;
    if (($countones({ext_en, g_out, r_out}) > 1) || !$onehot0(r_in)) begin
      failures++;
      $display("FAIL bus_exclusive: got ext=%b gout=%b rout=%b rin=%b required <=1 driver, rin onehot0",
               ext_en, g_out, r_out, r_in);
    end
    if (rst || time_step == 2'd0) begin
      check("idle_zero", act, '0);
    end else if (exp_q.size() == 0) begin
      check("unexpected_step", act, '0);
    end else begin
      check("step_outputs", act, exp_q.pop_front());
    end
  end

  initial begin
    obs_t z;
    z    = '0;
    rst  = 1'b1;
    exec = 1'b0;
    din  = '0;
    #2;
    check("reset_async", observe(), z);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    idle(5);

    run_instr(10'b0000_10_00_00, 1'b0, 10'd0);   // LOAD R2
    idle(1);
    run_instr(10'b0010_01_10_00, 1'b0, 10'd0);   // ADD R1,R2
    run_instr(10'b0111_11_00_00, 1'b0, 10'd5);   // SUBI R3,#5
    run_instr(10'b0011_10_01_00, 1'b1, 10'd0);   // SUB with exec re-pulsed
    run_instr(10'b1111_00_00_00, 1'b1, 10'd0);   // NOP
    run_instr(10'b0001_10_10_00, 1'b0, 10'd0);   // MOV self-load

    // Reset mid-T2 of ADD: outputs must clear in the same cycle.
    push_expected(10'b0010_00_01_00);
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    exec = 1'b1;
    din  = 10'b0010_00_01_00;
    @(posedge clk); #1;
    exec = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("reset_mid_t2", observe(), z);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    for (int k = 0; k < 300; k++) begin
      run_instr(10'($urandom), 1'($urandom_range(0, 1)), 10'($urandom));
      idle($urandom_range(0, 2));
    end

    idle(3);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL queue_drained: got %0d pending required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
